// File: rtl/fft_pingpong_buffer_if.sv
// Host stream, engine port and swap handshake of the FFT ping-pong buffer.
// master drives the requests; slave is the buffer itself.
interface fft_pingpong_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [3:0]            length_log2_i;
  logic                  host_wvalid_i;
  logic                  host_wready_o;
  logic [DATA_WIDTH-1:0] host_wdata_i;
  logic                  drain_en_i;
  logic                  host_rvalid_o;
  logic                  host_rready_i;
  logic [DATA_WIDTH-1:0] host_rdata_o;
  logic [ADDR_WIDTH-1:0] eng_addr_i;
  logic                  eng_we_i;
  logic [DATA_WIDTH-1:0] eng_wdata_i;
  logic                  eng_re_i;
  logic [DATA_WIDTH-1:0] eng_rdata_o;
  logic                  eng_rvalid_o;
  logic                  swap_i;
  logic                  swap_ack_o;
  logic                  swap_err_o;
  logic                  host_bank_o;
  logic                  load_done_o;
  logic                  drain_done_o;

  modport master (
    output length_log2_i, host_wvalid_i, host_wdata_i, drain_en_i, host_rready_i,
           eng_addr_i, eng_we_i, eng_wdata_i, eng_re_i, swap_i,
    input  host_wready_o, host_rvalid_o, host_rdata_o, eng_rdata_o, eng_rvalid_o,
           swap_ack_o, swap_err_o, host_bank_o, load_done_o, drain_done_o
  );

  modport slave (
    input  length_log2_i, host_wvalid_i, host_wdata_i, drain_en_i, host_rready_i,
           eng_addr_i, eng_we_i, eng_wdata_i, eng_re_i, swap_i,
    output host_wready_o, host_rvalid_o, host_rdata_o, eng_rdata_o, eng_rvalid_o,
           swap_ack_o, swap_err_o, host_bank_o, load_done_o, drain_done_o
  );
endinterface

// File: rtl/fft_pingpong_buffer.sv
// Two-bank FFT sample buffer: host streams load/drain one bank, the engine owns the other.
// Define FFT_BITREV_LOAD_EN to store loaded samples at bit-reversed addresses.
module fft_pingpong_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MIN_LOG2   = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  fft_pingpong_buffer_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int LW    = $clog2(ADDR_WIDTH + 1);

  typedef enum logic {NORMAL, SWAP_WAIT} state_e;
  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem0 [DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [DEPTH];

  logic [LW-1:0]         len_q, len_c;
  logic [PW-1:0]         n_c, wr_ptr_q, rd_ptr_q;
  logic                  host_bank_q, ack_q, err_q;
  logic                  rd_inflight_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  fifo_wr_q, fifo_rd_q;
  logic [1:0]            fifo_cnt_q, occ;
  logic                  eng_rvalid_q;
  logic [DATA_WIDTH-1:0] eng_rdata_q;

  logic load_done, w_acc, fifo_empty, host_idle, pop, issue, swap_exec;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] wa0, wa1;
  logic [DATA_WIDTH-1:0] wd0, wd1;

  always_comb begin
    if (int'(bus.length_log2_i) < MIN_LOG2)        len_c = LW'(MIN_LOG2);
    else if (int'(bus.length_log2_i) > ADDR_WIDTH) len_c = LW'(ADDR_WIDTH);
    else                                           len_c = LW'(bus.length_log2_i);
  end

  assign n_c        = PW'(1) << len_q;
  assign load_done  = (wr_ptr_q == n_c);
  assign w_acc      = bus.host_wvalid_i && !load_done && (state_q == NORMAL);
  assign fifo_empty = (fifo_cnt_q == 2'd0);
  assign host_idle  = fifo_empty && !rd_inflight_q;
  assign pop        = !fifo_empty && bus.host_rready_i;
  // A pop in this cycle frees its slot, which keeps the drain at one sample per cycle.
  assign occ        = fifo_cnt_q - {1'b0, pop} + {1'b0, rd_inflight_q};
  // No issue while a swap is requested or waiting, so a swapped bank never feeds stale reads.
  assign issue      = bus.drain_en_i && (rd_ptr_q < n_c) && (occ < 2'd2) &&
                      (state_q == NORMAL) && !bus.swap_i;

`ifdef FFT_BITREV_LOAD_EN
  logic [ADDR_WIDTH-1:0] wr_rev;
  always_comb begin
    wr_rev = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) wr_rev[i] = wr_ptr_q[ADDR_WIDTH-1-i];
  end
  assign load_addr = wr_rev >> (LW'(ADDR_WIDTH) - len_q);
`else
  assign load_addr = wr_ptr_q[ADDR_WIDTH-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    swap_exec = 1'b0;
    unique case (state_q)
      NORMAL: if (bus.swap_i) begin
        if (host_idle) swap_exec = 1'b1;
        else           state_d   = SWAP_WAIT;
      end
      SWAP_WAIT: if (!rd_inflight_q && (fifo_cnt_q == {1'b0, pop})) begin
        swap_exec = 1'b1;
        state_d   = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  assign we0 = host_bank_q ? bus.eng_we_i   : w_acc;
  assign wa0 = host_bank_q ? bus.eng_addr_i : load_addr;
  assign wd0 = host_bank_q ? bus.eng_wdata_i : bus.host_wdata_i;
  assign we1 = host_bank_q ? w_acc          : bus.eng_we_i;
  assign wa1 = host_bank_q ? load_addr      : bus.eng_addr_i;
  assign wd1 = host_bank_q ? bus.host_wdata_i : bus.eng_wdata_i;

  always_ff @(posedge clk_i) begin
    if (we0) mem0[wa0] <= wd0;
    if (we1) mem1[wa1] <= wd1;
    if (issue)
      rd_data_q <= host_bank_q ? mem1[rd_ptr_q[ADDR_WIDTH-1:0]] : mem0[rd_ptr_q[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      eng_rvalid_q <= 1'b0;
      eng_rdata_q  <= '0;
    end else begin
      eng_rvalid_q <= bus.eng_re_i;
      if (bus.eng_re_i)
        eng_rdata_q <= host_bank_q ? mem0[bus.eng_addr_i] : mem1[bus.eng_addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_inflight_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      fifo_wr_q     <= 1'b0;
      fifo_rd_q     <= 1'b0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
    end else begin
      rd_inflight_q <= issue;
      fifo_cnt_q    <= occ;
      if (rd_inflight_q) begin
        fifo_q[fifo_wr_q] <= rd_data_q;
        fifo_wr_q         <= ~fifo_wr_q;
      end
      if (pop) fifo_rd_q <= ~fifo_rd_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= NORMAL;
      host_bank_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= len_c;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= swap_exec;
      err_q   <= swap_exec && !load_done;
      if (swap_exec) begin
        host_bank_q <= ~host_bank_q;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        len_q       <= len_c;
      end else begin
        if (w_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (issue) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  assign bus.host_wready_o = !load_done && (state_q == NORMAL);
  assign bus.host_rvalid_o = !fifo_empty;
  assign bus.host_rdata_o  = fifo_q[fifo_rd_q];
  assign bus.eng_rdata_o   = eng_rdata_q;
  assign bus.eng_rvalid_o  = eng_rvalid_q;
  assign bus.swap_ack_o    = ack_q;
  assign bus.swap_err_o    = err_q;
  assign bus.host_bank_o   = host_bank_q;
  assign bus.load_done_o   = load_done;
  assign bus.drain_done_o  = (rd_ptr_q == n_c) && host_idle;
endmodule

// File: tb/tb_fft_pingpong_buffer.sv
// Bench for fft_pingpong_buffer: transaction-level model checked every cycle plus directed literals.
module tb_fft_pingpong_buffer;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_pingpong_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc();
  fft_pingpong_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MIN_LOG2(3)) dut (
    .clk_i(clk), .reset_i(rst), .bus(ifc.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

`ifdef FFT_BITREV_LOAD_EN
  int rev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
  int rev [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

  // ---------------- model: drain items carry the cycle they become visible
  typedef struct { logic [31:0] v; int t; } item_t;
  item_t       q[$];
  logic [31:0] m_mem [2][DEPTH];
  int          m_wcnt, m_rd, m_L, cyc;
  bit          m_bank, m_wait, m_ack, m_err, m_eng_v, started;
  logic [31:0] m_eng_d;

  function automatic int clamp_l(input logic [3:0] v);
    int l;
    l = int'(v);
    if (l < 3) l = 3;
    if (l > AW) l = AW;
    return l;
  endfunction

  function automatic int laddr(input int cnt, input int l);
`ifdef FFT_BITREV_LOAD_EN
    int a;
    a = 0;
    for (int i = 0; i < l; i++) if (cnt[i]) a = a | (1 << (l - 1 - i));
    return a;
`else
    return cnt;
`endif
  endfunction

  always @(posedge clk) begin : model
    int n;
    bit ld0, idle0, pop, issue, acc, ex;
    n = 1 << m_L;
    if (rst) begin
      q.delete();
      m_bank = 0; m_wcnt = 0; m_rd = 0; m_wait = 0;
      m_ack = 0; m_err = 0; m_eng_v = 0; m_eng_d = '0;
      m_L = clamp_l(ifc.length_log2_i);
      started = 1;
    end else begin
      ld0   = (m_wcnt == n);
      idle0 = (q.size() == 0);
      pop   = (q.size() > 0) && (q[0].t <= cyc) && ifc.host_rready_i;
      issue = ifc.drain_en_i && (m_rd < n) && !m_wait && !ifc.swap_i &&
              ((q.size() - int'(pop)) < 2);
      acc   = ifc.host_wvalid_i && !ld0 && !m_wait;
      if (ifc.eng_re_i) m_eng_d = m_mem[!m_bank][ifc.eng_addr_i];
      m_eng_v = ifc.eng_re_i;
      if (pop) void'(q.pop_front());
      if (issue) begin
        q.push_back('{v: m_mem[m_bank][m_rd], t: cyc + 2});
        m_rd++;
      end
      if (acc) begin
        m_mem[m_bank][laddr(m_wcnt, m_L)] = ifc.host_wdata_i;
        m_wcnt++;
      end
      if (ifc.eng_we_i) m_mem[!m_bank][ifc.eng_addr_i] = ifc.eng_wdata_i;
      ex = m_wait ? (q.size() == 0) : (ifc.swap_i && idle0);
      m_ack = ex;
      m_err = ex && !ld0;
      if (ex) begin
        m_bank = !m_bank; m_wcnt = 0; m_rd = 0; m_wait = 0;
        m_L = clamp_l(ifc.length_log2_i);
      end else if (ifc.swap_i) m_wait = 1;
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    int n;
    bit rv;
    if (started) begin
      n  = 1 << m_L;
      rv = (q.size() > 0) && (q[0].t <= cyc);
      chk("host_bank",  ifc.host_bank_o,   m_bank);
      chk("load_done",  ifc.load_done_o,   m_wcnt == n);
      chk("wready",     ifc.host_wready_o, (m_wcnt != n) && !m_wait);
      chk("drain_done", ifc.drain_done_o,  (m_rd == n) && (q.size() == 0));
      chk("rvalid",     ifc.host_rvalid_o, rv);
      if (rv) chk("rdata", ifc.host_rdata_o, q[0].v);
      chk("swap_ack",   ifc.swap_ack_o,    m_ack);
      chk("swap_err",   ifc.swap_err_o,    m_err);
      chk("eng_rvalid", ifc.eng_rvalid_o,  m_eng_v);
      if (m_eng_v) chk("eng_rdata", ifc.eng_rdata_o, m_eng_d);
    end
  end

  // ---------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_swap();
    ifc.swap_i = 1'b1;
    step();
    ifc.swap_i = 1'b0;
  endtask

  task automatic load(input int cnt, input int base, input string tag);
    for (int i = 0; i < cnt; i++) begin
      ifc.host_wvalid_i = 1'b1;
      ifc.host_wdata_i  = base + i;
      step();
    end
    ifc.host_wvalid_i = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : stim
    int          npop;
    logic [31:0] got [8];

    ifc.length_log2_i = 4'd3;
    ifc.host_wvalid_i = 0; ifc.host_wdata_i = '0; ifc.drain_en_i = 0; ifc.host_rready_i = 0;
    ifc.eng_addr_i = '0; ifc.eng_we_i = 0; ifc.eng_wdata_i = '0; ifc.eng_re_i = 0; ifc.swap_i = 0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_bank", ifc.host_bank_o, 0);     chk("rst_ld", ifc.load_done_o, 0);
    chk("rst_dd", ifc.drain_done_o, 0);      chk("rst_rv", ifc.host_rvalid_o, 0);
    chk("rst_erv", ifc.eng_rvalid_o, 0);     chk("rst_ack", ifc.swap_ack_o, 0);
    chk("rst_err", ifc.swap_err_o, 0);       chk("rst_wr", ifc.host_wready_o, 1);
    chk("rst_rd", ifc.host_rdata_o, 0);      chk("rst_erd", ifc.eng_rdata_o, 0);
    step();
    rst = 1'b0;

    // load 8 words, 9th attempt must be refused
    load(7, 32'h10, "l1");
    ifc.host_wvalid_i = 1'b1; ifc.host_wdata_i = 32'h17;
    @(negedge clk); chk("ld_before_8th", ifc.load_done_o, 0);
    step();
    ifc.host_wdata_i = 32'h99;
    @(negedge clk); chk("ld_after_8th", ifc.load_done_o, 1); chk("wready_9th", ifc.host_wready_o, 0);
    step();
    ifc.host_wvalid_i = 1'b0;

    do_swap();
    @(negedge clk);
    chk("swap1_ack", ifc.swap_ack_o, 1); chk("swap1_err", ifc.swap_err_o, 0);
    chk("swap1_bank", ifc.host_bank_o, 1); chk("swap1_wr", ifc.host_wready_o, 1);
    step();

    // engine reads of the loaded frame
    for (int a = 0; a <= 8; a++) begin
      ifc.eng_re_i = (a < 8); ifc.eng_addr_i = AW'(a % 8);
      @(negedge clk);
      if (a > 0) begin
        chk("eng_rv", ifc.eng_rvalid_o, 1);
        chk("eng_rd", ifc.eng_rdata_o, 32'h10 + rev[a-1]);
      end
      step();
    end
    // same-address engine read+write returns old data
    ifc.eng_re_i = 1; ifc.eng_we_i = 1; ifc.eng_addr_i = AW'(2); ifc.eng_wdata_i = 32'hAA;
    step();
    ifc.eng_we_i = 0;
    @(negedge clk); chk("eng_rw_old", ifc.eng_rdata_o, 32'h10 + rev[2]);
    step();
    ifc.eng_re_i = 0;
    @(negedge clk); chk("eng_rw_new", ifc.eng_rdata_o, 32'hAA);
    step();

    // drain with a toggling consumer
    load(8, 32'h20, "l2");
    ifc.drain_en_i = 1'b1;
    npop = 0;
    for (int t = 0; t < 40; t++) begin
      ifc.host_rready_i = t[0];
      @(negedge clk);
      if (ifc.host_rvalid_o && ifc.host_rready_i && npop < 8) begin
        got[npop] = ifc.host_rdata_o;
        npop++;
      end
      step();
    end
    ifc.drain_en_i = 0; ifc.host_rready_i = 0;
    chk("drain_cnt", npop, 8);
    for (int i = 0; i < 8; i++) chk("drain_val", got[i], 32'h20 + rev[i]);
    @(negedge clk); chk("drain_done", ifc.drain_done_o, 1);
    step();

    // deferred swap with two FIFO entries pending
    do_swap();
    step();
    ifc.drain_en_i = 1'b1;
    repeat (5) step();
    ifc.drain_en_i = 1'b0;
    @(negedge clk); chk("fifo_full_rv", ifc.host_rvalid_o, 1);
    step();
    do_swap();
    @(negedge clk); chk("wait_wready", ifc.host_wready_o, 0); chk("wait_ack0", ifc.swap_ack_o, 0);
    step();
    ifc.host_rready_i = 1'b1;
    @(negedge clk); chk("pop1_ack", ifc.swap_ack_o, 0);
    step();
    @(negedge clk); chk("pop2_ack", ifc.swap_ack_o, 0);
    step();
    ifc.host_rready_i = 1'b0;
    @(negedge clk);
    chk("def_ack", ifc.swap_ack_o, 1); chk("def_err", ifc.swap_err_o, 1);
    chk("def_bank", ifc.host_bank_o, 1);
    step();

    // early swap after 5 of 8 loads
    load(5, 32'h30, "l3");
    do_swap();
    @(negedge clk);
    chk("early_ack", ifc.swap_ack_o, 1); chk("early_err", ifc.swap_err_o, 1);
    chk("early_bank", ifc.host_bank_o, 0); chk("early_ld", ifc.load_done_o, 0);
    step();
    load(8, 32'h40, "l4");
    @(negedge clk); chk("reload_done", ifc.load_done_o, 1);
    step();

    // length clamping: 15 -> 1024, 1 -> 8
    ifc.length_log2_i = 4'd15;
    do_swap();
    load(1023, 32'h100, "l5");
    @(negedge clk); chk("n1024_pre", ifc.load_done_o, 0);
    step();
    load(1, 32'h500, "l6");
    @(negedge clk); chk("n1024_done", ifc.load_done_o, 1);
    step();
    ifc.length_log2_i = 4'd1;
    do_swap();
    load(7, 32'h60, "l7");
    @(negedge clk); chk("n8_pre", ifc.load_done_o, 0);
    step();
    load(1, 32'h67, "l8");
    @(negedge clk); chk("n8_done", ifc.load_done_o, 1);
    step();

    // reset during SWAP_WAIT discards the swap
    do_swap();
    ifc.drain_en_i = 1'b1;
    repeat (4) step();
    ifc.drain_en_i = 1'b0;
    do_swap();
    @(negedge clk); chk("rw_wait", ifc.host_wready_o, 0); chk("rw_bank1", ifc.host_bank_o, 1);
    step();
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk); chk("rw_noack", ifc.swap_ack_o, 0);
      step();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rw_bank0", ifc.host_bank_o, 0); chk("rw_ack", ifc.swap_ack_o, 0);
    chk("rw_wready", ifc.host_wready_o, 1);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
